// File: rtl/mmb_arbiter_2x1.sv
// mmb_arbiter_2x1
// Round-robin arbiter that lets two burst memory-mapped masters share one
// burst memory-mapped slave. A grant is held for a whole write burst or for
// one read request. Accepted reads are logged in a small FIFO so that read
// responses from the slave are routed back to the port that issued them.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   s0_* / s1_*               requester side: addr, bcnt, wreq, wdat, rreq in;
//                             rdat, rval, busy out
//   m_addr/m_bcnt/m_wreq/
//   m_wdat/m_rreq             to the slave (mux of the granted requester)
//   m_rdat/m_rval/m_busy      from the slave
//   err_orphan                sticky flag: read data arrived with no read pending
module mmb_arbiter_2x1 #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned BWIDTH    = 8,
  parameter int unsigned RDPENDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [AWIDTH-1:0] s0_addr,
  input  logic [BWIDTH-1:0] s0_bcnt,
  input  logic              s0_wreq,
  input  logic [DWIDTH-1:0] s0_wdat,
  input  logic              s0_rreq,
  output logic [DWIDTH-1:0] s0_rdat,
  output logic              s0_rval,
  output logic              s0_busy,

  input  logic [AWIDTH-1:0] s1_addr,
  input  logic [BWIDTH-1:0] s1_bcnt,
  input  logic              s1_wreq,
  input  logic [DWIDTH-1:0] s1_wdat,
  input  logic              s1_rreq,
  output logic [DWIDTH-1:0] s1_rdat,
  output logic              s1_rval,
  output logic              s1_busy,

  output logic [AWIDTH-1:0] m_addr,
  output logic [BWIDTH-1:0] m_bcnt,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy,

  output logic              err_orphan
);

  localparam int unsigned PW = (RDPENDING > 1) ? $clog2(RDPENDING) : 1;
  localparam int unsigned CW = $clog2(RDPENDING + 1);
  localparam logic [BWIDTH:0] CNT_ONE = {{BWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // bcnt of zero encodes the maximum burst of 2^BWIDTH words.
  function automatic logic [BWIDTH:0] burst_len(input logic [BWIDTH-1:0] b);
    burst_len = (b == '0) ? {1'b1, {BWIDTH{1'b0}}} : {1'b0, b};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(RDPENDING - 1)) ? '0 : p + PW'(1);
  endfunction

  state_t          state, state_nxt;
  logic            sel;
  logic            last;
  logic [BWIDTH:0] wcnt;

  // Pending-read queue
  logic            q_port [RDPENDING];
  logic [BWIDTH-1:0] q_bcnt [RDPENDING];
  logic [PW-1:0]   q_wptr, q_rptr;
  logic [CW-1:0]   q_cnt;
  logic [BWIDTH:0] rcnt;
  logic            q_full, q_empty;

  // Selected requester
  logic [AWIDTH-1:0] s_addr;
  logic [BWIDTH-1:0] s_bcnt;
  logic              s_wreq, s_rreq;
  logic [DWIDTH-1:0] s_wdat;

  logic cand0, cand1, any_cand;
  logic grant_port, grant_wr;
  logic wr_acc, wr_last, rd_acc;
  logic push, pop, rsp_valid, head_port;

  assign q_full  = (q_cnt == CW'(RDPENDING));
  assign q_empty = (q_cnt == '0);

  assign s_addr = sel ? s1_addr : s0_addr;
  assign s_bcnt = sel ? s1_bcnt : s0_bcnt;
  assign s_wreq = sel ? s1_wreq : s0_wreq;
  assign s_rreq = sel ? s1_rreq : s0_rreq;
  assign s_wdat = sel ? s1_wdat : s0_wdat;

  // A read only competes while the pending-read queue can take another entry.
  assign cand0    = s0_wreq | (s0_rreq & ~q_full);
  assign cand1    = s1_wreq | (s1_rreq & ~q_full);
  assign any_cand = cand0 | cand1;

  always_comb begin
    grant_port = 1'b0;
    if (cand0 && cand1) begin
      grant_port = ~last;
    end else begin
      grant_port = cand1;
    end
    grant_wr = grant_port ? s1_wreq : s0_wreq;
  end

  assign wr_acc  = (state == WR) && s_wreq && !m_busy;
  assign wr_last = wr_acc && (wcnt == CNT_ONE);
  assign rd_acc  = (state == RD) && s_rreq && !m_busy;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_cand) begin
          state_nxt = grant_wr ? WR : RD;
        end
      end
      RD: begin
        if (rd_acc) begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        if (wr_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Only the request type matching the grant is forwarded so a
  // stray wreq during a read grant (or rreq during a write) never reaches the slave.
  always_comb begin
    m_addr  = s_addr;
    m_bcnt  = s_bcnt;
    m_wdat  = s_wdat;
    m_wreq  = 1'b0;
    m_rreq  = 1'b0;
    s0_busy = 1'b1;
    s1_busy = 1'b1;
    case (state)
      RD: begin
        m_rreq = s_rreq;
        if (sel) begin
          s1_busy = m_busy;
        end else begin
          s0_busy = m_busy;
        end
      end
      WR: begin
        m_wreq = s_wreq;
        if (sel) begin
          s1_busy = m_busy;
        end else begin
          s0_busy = m_busy;
        end
      end
      default: begin
        m_wreq = 1'b0;
        m_rreq = 1'b0;
      end
    endcase
  end

  // Grant pointer, round-robin pointer and write word counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel  <= 1'b0;
      last <= 1'b1;
      wcnt <= '0;
    end else begin
      if (state == IDLE && any_cand) begin
        sel  <= grant_port;
        wcnt <= burst_len(grant_port ? s1_bcnt : s0_bcnt);
      end else if (wr_acc) begin
        wcnt <= wcnt - CNT_ONE;
      end
      if (rd_acc || wr_last) begin
        last <= sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-read queue and response routing
  // ---------------------------------------------------------------------------
  assign push      = rd_acc;
  assign head_port = q_port[q_rptr];
  assign rsp_valid = m_rval && !q_empty;
  assign pop       = rsp_valid && (rcnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (push) begin
      q_port[q_wptr] <= sel;
      q_bcnt[q_wptr] <= s_bcnt;
    end
  end

  // rcnt always holds the words still owed to the head entry. On a pop it is
  // reloaded from the next stored entry, or from the entry being pushed in the
  // same cycle when that one becomes the new head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_wptr <= '0;
      q_rptr <= '0;
      q_cnt  <= '0;
      rcnt   <= '0;
    end else begin
      if (push) begin
        q_wptr <= ptr_inc(q_wptr);
      end
      if (pop) begin
        q_rptr <= ptr_inc(q_rptr);
      end
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CW'(1);
        2'b01:   q_cnt <= q_cnt - CW'(1);
        default: q_cnt <= q_cnt;
      endcase
      if (pop) begin
        if (q_cnt > CW'(1)) begin
          rcnt <= burst_len(q_bcnt[ptr_inc(q_rptr)]);
        end else if (push) begin
          rcnt <= burst_len(s_bcnt);
        end else begin
          rcnt <= '0;
        end
      end else if (rsp_valid) begin
        rcnt <= rcnt - CNT_ONE;
      end else if (push && q_empty) begin
        rcnt <= burst_len(s_bcnt);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_orphan <= 1'b0;
    end else if (m_rval && q_empty) begin
      err_orphan <= 1'b1;
    end
  end

  assign s0_rdat = m_rdat;
  assign s1_rdat = m_rdat;
  assign s0_rval = rsp_valid && !head_port;
  assign s1_rval = rsp_valid && head_port;

endmodule

// File: tb/tb_mmb_arbiter_2x1.sv
module tb_mmb_arbiter_2x1;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned RP = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] s0_addr, s1_addr, m_addr;
  logic [BW-1:0] s0_bcnt, s1_bcnt, m_bcnt;
  logic          s0_wreq, s1_wreq, s0_rreq, s1_rreq;
  logic [DW-1:0] s0_wdat, s1_wdat, s0_rdat, s1_rdat;
  logic          s0_rval, s1_rval, s0_busy, s1_busy;
  logic          m_wreq, m_rreq, m_rval, m_busy;
  logic [DW-1:0] m_wdat, m_rdat;
  logic          err_orphan;

  always #5 clk = ~clk;

  mmb_arbiter_2x1 #(
    .DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .RDPENDING(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_addr(s0_addr), .s0_bcnt(s0_bcnt), .s0_wreq(s0_wreq), .s0_wdat(s0_wdat),
    .s0_rreq(s0_rreq), .s0_rdat(s0_rdat), .s0_rval(s0_rval), .s0_busy(s0_busy),
    .s1_addr(s1_addr), .s1_bcnt(s1_bcnt), .s1_wreq(s1_wreq), .s1_wdat(s1_wdat),
    .s1_rreq(s1_rreq), .s1_rdat(s1_rdat), .s1_rval(s1_rval), .s1_busy(s1_busy),
    .m_addr(m_addr), .m_bcnt(m_bcnt), .m_wreq(m_wreq), .m_wdat(m_wdat),
    .m_rreq(m_rreq), .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy),
    .err_orphan(err_orphan)
  );

  int checks = 0;
  int errors = 0;

  // Expected owner of each future response word, pushed when a read is issued.
  bit exp_port_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin : rsp_mon
    bit p;
    if (reset_n && m_rval) begin
      if (exp_port_q.size() > 0) begin
        p = exp_port_q.pop_front();
        check("rsp_s0_rval", s0_rval, !p);
        check("rsp_s1_rval", s1_rval, p);
        check("rsp_rdat", p ? s1_rdat : s0_rdat, m_rdat);
      end else begin
        check("orphan_s0_rval", s0_rval, 1'b0);
        check("orphan_s1_rval", s1_rval, 1'b0);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s0_wreq = 1'b0; s0_rreq = 1'b0;
    s1_wreq = 1'b0; s1_rreq = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    m_busy = 1'b0;
    m_rval = 1'b0;
    exp_port_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s0_busy"}, s0_busy, 1'b1);
    check({tag, "_s1_busy"}, s1_busy, 1'b1);
    check({tag, "_m_wreq"}, m_wreq, 1'b0);
    check({tag, "_m_rreq"}, m_rreq, 1'b0);
  endtask

  // One read request from an otherwise idle arbiter; starts and ends at a drive point.
  task automatic do_read(input bit port, input logic [BW-1:0] bcnt, input logic [AW-1:0] addr);
    int n;
    if (port) begin
      s1_addr = addr; s1_bcnt = bcnt; s1_rreq = 1'b1;
    end else begin
      s0_addr = addr; s0_bcnt = bcnt; s0_rreq = 1'b1;
    end
    cyc();
    neg();
    check("rd_m_rreq", m_rreq, 1'b1);
    check("rd_m_addr", m_addr, addr);
    check("rd_busy", port ? s1_busy : s0_busy, 1'b0);
    cyc();
    s0_rreq = 1'b0; s1_rreq = 1'b0;
    n = (bcnt == '0) ? (1 << BW) : int'(bcnt);
    for (int k = 0; k < n; k++) exp_port_q.push_back(port);
  endtask

  typedef struct {
    bit w0, r0, w1, r1;
    bit exp_port;
    bit exp_wr;
  } arb_vec_t;

  typedef struct {
    bit w1, mbusy;
    bit exp_mwreq, exp_s1busy, exp_s0busy;
  } wr_step_t;

  arb_vec_t arb_tab[9];
  wr_step_t wr_tab[9];

  initial begin
    logic [AW-1:0] exp_addr;
    int acc;

    // Arbitration sequence from reset (port 1 counts as last served)
    arb_tab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    arb_tab[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    arb_tab[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    arb_tab[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    arb_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    arb_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    arb_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    arb_tab[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    arb_tab[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Port 1 write of 3 words with gaps and slave stalls
    wr_tab[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    wr_tab[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    wr_tab[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wr_tab[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wr_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    wr_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wr_tab[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    wr_tab[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wr_tab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n = 1'b0;
    s0_addr = '0; s1_addr = '0; s0_bcnt = '0; s1_bcnt = '0;
    s0_wdat = '0; s1_wdat = '0;
    idle_inputs();
    m_busy = 1'b0; m_rval = 1'b0; m_rdat = '0;

    // ---------------- reset state ----------------
    neg();
    check_idle("reset");
    check("reset_s0_rval", s0_rval, 1'b0);
    check("reset_s1_rval", s1_rval, 1'b0);
    check("reset_err_orphan", err_orphan, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // ---------------- arbitration table ----------------
    for (int i = 0; i < 9; i++) begin
      s0_addr = 32'hA000_0000 | i;
      s1_addr = 32'hB000_0000 | i;
      s0_bcnt = 8'd1; s1_bcnt = 8'd1;
      s0_wreq = arb_tab[i].w0; s0_rreq = arb_tab[i].r0;
      s1_wreq = arb_tab[i].w1; s1_rreq = arb_tab[i].r1;
      exp_addr = arb_tab[i].exp_port ? (32'hB000_0000 | i) : (32'hA000_0000 | i);
      neg();
      check_idle($sformatf("arb%0d_idle", i));
      cyc();
      neg();
      check($sformatf("arb%0d_m_wreq", i), m_wreq, arb_tab[i].exp_wr);
      check($sformatf("arb%0d_m_rreq", i), m_rreq, !arb_tab[i].exp_wr);
      check($sformatf("arb%0d_s0_busy", i), s0_busy, arb_tab[i].exp_port);
      check($sformatf("arb%0d_s1_busy", i), s1_busy, !arb_tab[i].exp_port);
      check($sformatf("arb%0d_m_addr", i), m_addr, exp_addr);
      cyc();
      idle_inputs();
      if (!arb_tab[i].exp_wr) begin
        exp_port_q.push_back(arb_tab[i].exp_port);
        m_rval = 1'b1; m_rdat = 8'h40 + 8'(i);
        neg();
        cyc();
        m_rval = 1'b0;
      end
    end

    // ---------------- port 0 write, 4 words at 0x10 ----------------
    s0_addr = 32'h10; s0_bcnt = 8'd4; s0_wreq = 1'b1; s0_wdat = 8'hD0;
    neg();
    check_idle("wr4_idle");
    cyc();
    for (int k = 0; k < 4; k++) begin
      s0_wdat = 8'hD0 + 8'(k);
      neg();
      check($sformatf("wr4_w%0d_m_wreq", k), m_wreq, 1'b1);
      check($sformatf("wr4_w%0d_m_addr", k), m_addr, 32'h10);
      check($sformatf("wr4_w%0d_m_bcnt", k), m_bcnt, 8'd4);
      check($sformatf("wr4_w%0d_m_wdat", k), m_wdat, 8'hD0 + 8'(k));
      check($sformatf("wr4_w%0d_s0_busy", k), s0_busy, 1'b0);
      check($sformatf("wr4_w%0d_s1_busy", k), s1_busy, 1'b1);
      cyc();
    end
    s0_wreq = 1'b0;
    neg();
    check_idle("wr4_done");
    cyc();

    // ---------------- simultaneous reads after reset ----------------
    do_reset();
    s0_addr = 32'h200; s0_bcnt = 8'd2; s0_rreq = 1'b1;
    s1_addr = 32'h300; s1_bcnt = 8'd3; s1_rreq = 1'b1;
    neg();
    check_idle("rr_idle0");
    cyc();
    neg();
    check("rr_g0_m_rreq", m_rreq, 1'b1);
    check("rr_g0_m_addr", m_addr, 32'h200);
    check("rr_g0_m_bcnt", m_bcnt, 8'd2);
    check("rr_g0_s0_busy", s0_busy, 1'b0);
    check("rr_g0_s1_busy", s1_busy, 1'b1);
    cyc();
    s0_rreq = 1'b0;
    exp_port_q.push_back(1'b0); exp_port_q.push_back(1'b0);
    neg();
    check_idle("rr_idle1");
    cyc();
    neg();
    check("rr_g1_m_rreq", m_rreq, 1'b1);
    check("rr_g1_m_addr", m_addr, 32'h300);
    check("rr_g1_m_bcnt", m_bcnt, 8'd3);
    check("rr_g1_s0_busy", s0_busy, 1'b1);
    check("rr_g1_s1_busy", s1_busy, 1'b0);
    cyc();
    s1_rreq = 1'b0;
    for (int k = 0; k < 3; k++) exp_port_q.push_back(1'b1);
    for (int k = 0; k < 5; k++) begin
      m_rval = 1'b1; m_rdat = 8'h50 + 8'(k);
      neg();
      cyc();
    end
    m_rval = 1'b0;

    // ---------------- port 1 write with gaps and stalls ----------------
    s1_addr = 32'h400; s1_bcnt = 8'd3;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      s1_wreq = wr_tab[i].w1; m_busy = wr_tab[i].mbusy; s1_wdat = 8'h60 + 8'(i);
      neg();
      check($sformatf("gap%0d_m_wreq", i), m_wreq, wr_tab[i].exp_mwreq);
      check($sformatf("gap%0d_s1_busy", i), s1_busy, wr_tab[i].exp_s1busy);
      check($sformatf("gap%0d_s0_busy", i), s0_busy, wr_tab[i].exp_s0busy);
      if (m_wreq && !m_busy) acc++;
      cyc();
    end
    check("gap_accepted_words", acc, 3);
    m_busy = 1'b0;
    s0_addr = 32'h480; s0_bcnt = 8'd1; s0_wreq = 1'b1;
    s1_addr = 32'h490; s1_bcnt = 8'd1; s1_wreq = 1'b1;
    neg();
    cyc();
    neg();
    check("gap_rr_s0_busy", s0_busy, 1'b0);
    check("gap_rr_s1_busy", s1_busy, 1'b1);
    check("gap_rr_m_addr", m_addr, 32'h480);
    cyc();
    idle_inputs();

    // ---------------- pending-read queue full ----------------
    do_reset();
    do_read(1'b0, 8'd2, 32'h500);
    do_read(1'b1, 8'd1, 32'h504);
    do_read(1'b0, 8'd1, 32'h508);
    do_read(1'b1, 8'd1, 32'h50C);
    s0_addr = 32'h600; s0_bcnt = 8'd1; s0_rreq = 1'b1;
    s1_addr = 32'h700; s1_bcnt = 8'd1; s1_wreq = 1'b1; s1_wdat = 8'h77;
    neg();
    check_idle("full_idle");
    cyc();
    neg();
    check("full_wr_m_wreq", m_wreq, 1'b1);
    check("full_wr_m_rreq", m_rreq, 1'b0);
    check("full_wr_s1_busy", s1_busy, 1'b0);
    check("full_wr_s0_busy", s0_busy, 1'b1);
    check("full_wr_m_addr", m_addr, 32'h700);
    cyc();
    s1_wreq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k >= 3) begin
        m_rval = 1'b1; m_rdat = 8'h90 + 8'(k);
      end
      neg();
      check($sformatf("full_hold%0d_m_rreq", k), m_rreq, 1'b0);
      check($sformatf("full_hold%0d_s0_busy", k), s0_busy, 1'b1);
      cyc();
    end
    m_rval = 1'b0;
    neg();
    check("full_free_idle_m_rreq", m_rreq, 1'b0);
    cyc();
    neg();
    check("full_rd5_m_rreq", m_rreq, 1'b1);
    check("full_rd5_s0_busy", s0_busy, 1'b0);
    check("full_rd5_m_addr", m_addr, 32'h600);
    cyc();
    s0_rreq = 1'b0;
    exp_port_q.push_back(1'b0);
    for (int k = 0; k < 4; k++) begin
      m_rval = 1'b1; m_rdat = 8'hA0 + 8'(k);
      neg();
      cyc();
    end
    m_rval = 1'b0;

    // ---------------- maximum burst read, then an orphan ----------------
    do_read(1'b1, 8'd0, 32'h800);
    neg();
    check("max_err_orphan_before", err_orphan, 1'b0);
    cyc();
    for (int k = 0; k < 256; k++) begin
      m_rval = 1'b1; m_rdat = 8'(k);
      neg();
      cyc();
    end
    check("max_scoreboard_drained", exp_port_q.size(), 0);
    m_rval = 1'b1; m_rdat = 8'hEE;
    neg();
    cyc();
    m_rval = 1'b0;
    neg();
    check("max_err_orphan_after", err_orphan, 1'b1);
    cyc();

    // ---------------- reset in the middle of a write burst ----------------
    do_read(1'b1, 8'd2, 32'h900);
    s0_addr = 32'hA00; s0_bcnt = 8'd4; s0_wreq = 1'b1;
    cyc();
    cyc();
    cyc();
    neg();
    check("rst_mid_m_wreq_before", m_wreq, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_m_wreq", m_wreq, 1'b0);
    check("rst_mid_s0_busy", s0_busy, 1'b1);
    check("rst_mid_s1_busy", s1_busy, 1'b1);
    check("rst_mid_err_orphan", err_orphan, 1'b0);
    exp_port_q.delete();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_rval = 1'b1; m_rdat = 8'h5A;
    neg();
    cyc();
    m_rval = 1'b0;
    neg();
    check("rst_mid_orphan_after", err_orphan, 1'b1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmb_arbiter_2x1.md
Name: mmb_arbiter_2x1

Overview:
Round-robin arbiter that shares one burst MemoryMapped slave between two burst MemoryMapped masters. It locks the grant for the full duration of a write burst or a read request phase. It tracks outstanding read bursts in an internal queue and routes read responses back to the requester that issued them. It sits between bus masters (DMA, CPU bridge, test models) and a single memory controller or interconnect port.

Parameters:
DWIDTH, 8, data width
AWIDTH, 32, address width
BWIDTH, 8, burst count width; bcnt = 0 encodes 2^BWIDTH words
RDPENDING, 4, max outstanding read bursts (pending-read queue depth, >= 1)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
s0_addr/s1_addr  in  AWIDTH  requester address
s0_bcnt/s1_bcnt  in  BWIDTH  requester burst count
s0_wreq/s1_wreq  in  1  requester write request (one word per accepted cycle)
s0_wdat/s1_wdat  in  DWIDTH  requester write data
s0_rreq/s1_rreq  in  1  requester read request
s0_rdat/s1_rdat  out  DWIDTH  read data, m_rdat broadcast to both ports
s0_rval/s1_rval  out  1  read data valid for this port
s0_busy/s1_busy  out  1  stall to requester
m_addr  out  AWIDTH  to slave
m_bcnt  out  BWIDTH  to slave
m_wreq  out  1  to slave
m_wdat  out  DWIDTH  to slave
m_rreq  out  1  to slave
m_rdat  in  DWIDTH  from slave
m_rval  in  1  from slave
m_busy  in  1  from slave
err_orphan  out  1  sticky: m_rval received while the pending-read queue is empty

Behaviour:
- Protocol. A word or request is accepted in a cycle where req=1 and busy=0. A write burst is bcnt accepted wreq words, with addr and bcnt held constant. The master may drop wreq between words. A read is one accepted rreq; the slave then returns bcnt words in order via m_rval.
- State machine: IDLE, RD, WR. Grant pointer sel is registered. Round-robin pointer last is set to the port of the most recently completed grant.
- IDLE:
  - Both s*_busy=1; m_wreq=m_rreq=0.
  - A port is a candidate if it asserts wreq, or asserts rreq while the queue is not full.
  - If a port asserts both wreq and rreq, wreq wins.
  - If both ports are candidates, the port != last wins.
  - On a winner: sel<=port; go WR (load wcnt <= bcnt, with 0 meaning 2^BWIDTH, BWIDTH+1 bits) or go RD.
- RD and WR:
  - m_* is a combinational mux of s_sel. s_sel_busy = m_busy. The other port's busy = 1.
- RD: on m_rreq & ~m_busy, push {sel, bcnt} into the queue, set last<=sel, go IDLE.
- WR: on m_wreq & ~m_busy, decrement wcnt. When wcnt==1 at acceptance, set last<=sel and go IDLE.
- Grant latency: a request first seen in IDLE at cycle t is forwarded at t+1. The earliest acceptance is t+1. There are at least 2 cycles between consecutive grants.
- Response routing:
  - A head-of-queue response counter rcnt is loaded from the entry's bcnt (0 → 2^BWIDTH).
  - Each m_rval asserts s{head.port}_rval for that cycle (combinational) and decrements rcnt.
  - On the last word, pop the queue and load the next entry.
  - A push and pop in the same cycle are both honoured.
  - Full: RDPENDING entries. In that state reads are not granted, but writes may still be granted.
- Orphan: m_rval with the queue empty drives no s*_rval and sets err_orphan=1. err_orphan clears only on reset.
- Reset values: state=IDLE, last=1 (port 0 wins the first tie), queue empty, rcnt=0, err_orphan=0. Outputs: m_wreq=m_rreq=0, s*_busy=1, s*_rval=0.
- Reset mid-burst aborts the grant and discards all pending reads. Responses arriving after reset are treated as orphans.

Test Plan:
- Port 0 writes addr=0x10, bcnt=4, m_busy=0 → idle 1 cycle; m_wreq for 4 cycles with m_addr=0x10; port 1 busy throughout; return to IDLE.
- Both ports issue rreq simultaneously after reset (bcnt 2 and 3) → port 0 granted first, then port 1. Slave returns 5 words → s0_rval on the first 2, s1_rval on the next 3.
- Port 1 write bcnt=3 with wreq gaps and m_busy toggling → exactly 3 accepted words, grant held until the third, then pointer favours port 0.
- RDPENDING=4 reads queued with no responses → the 5th rreq stays busy, while a concurrent port write is still granted. The first response burst completes → the 5th read is granted.
- bcnt=0 read → 2^BWIDTH (256) responses routed before the pop. An extra m_rval with the queue empty → err_orphan=1, no s*_rval.
- reset_n low mid write burst → m_wreq=0 immediately, s*_busy=1, queue empty, err_orphan=0.
